// File: rtl/branch_cmp_seq.sv
// branch_cmp_seq: multi-cycle RV32 branch resolver comparing rs1/rs2 one CHUNK at a time, MSB chunk first.
// Build option: define BRCMP_EARLY_EXIT_EN to leave BUSY on the first differing chunk (variable latency).

module branch_cmp_seq #(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] dataA,
    input  logic [XLEN-1:0] dataB,
    input  logic [2:0]      funct3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            brEq,
    output logic            brLt,
    output logic            taken,
    output logic            illegal
);

    // state | meaning
    // IDLE  | ready for a request, operands not held
    // BUSY  | comparing one chunk per cycle, chunksLeft counts down to 0
    // DONE  | result held on the outputs until out_ready

    localparam int N     = XLEN / CHUNK;
    localparam int CW    = (N > 1) ? $clog2(N) : 1;
    localparam int SHIFT = (N > 1) ? CHUNK : 0;
    localparam logic [XLEN-1:0] MSB_MASK = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

    stateT           state;
    stateT           stateNext;
    logic [XLEN-1:0] opA;
    logic [XLEN-1:0] opB;
    logic [2:0]      f3Lat;
    logic [CW-1:0]   chunksLeft;
    logic            diffSeen;
    logic            ltSeen;

    logic [CHUNK-1:0] chunkA;
    logic [CHUNK-1:0] chunkB;
    logic             chunkDiff;
    logic             chunkLt;
    logic             lastChunk;
    logic             exitBusy;
    logic             accept;
    logic             resEq;
    logic             resLt;
    logic             resTaken;
    logic             resIllegal;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // Operands shift left each BUSY cycle, so the chunk under test is always the top one.
    assign chunkA    = opA[XLEN-1 -: CHUNK];
    assign chunkB    = opB[XLEN-1 -: CHUNK];
    assign chunkDiff = (chunkA != chunkB);
    assign chunkLt   = (chunkA < chunkB);
    assign lastChunk = (chunksLeft == '0);

`ifdef BRCMP_EARLY_EXIT_EN
    assign exitBusy = lastChunk || chunkDiff;
`else
    assign exitBusy = lastChunk;
`endif

    always_comb begin
        resEq = !(diffSeen || chunkDiff);
        resLt = 1'b0;
        if (diffSeen) begin
            resLt = ltSeen;
        end else if (chunkDiff) begin
            resLt = chunkLt;
        end
    end

    always_comb begin
        resTaken   = 1'b0;
        resIllegal = 1'b0;
        case (f3Lat)
            3'b000:          resTaken = resEq;
            3'b001:          resTaken = !resEq;
            3'b100, 3'b110:  resTaken = resLt;
            3'b101, 3'b111:  resTaken = !resLt;
            default:         resIllegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (in_valid)  stateNext = BUSY;
            BUSY: if (exitBusy)  stateNext = DONE;
            DONE: if (out_ready) stateNext = IDLE;
            default:             stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opA        <= '0;
            opB        <= '0;
            f3Lat      <= '0;
            chunksLeft <= '0;
            diffSeen   <= 1'b0;
            ltSeen     <= 1'b0;
            brEq       <= 1'b0;
            brLt       <= 1'b0;
            taken      <= 1'b0;
            illegal    <= 1'b0;
        end else if (accept) begin
            // Flipping the sign bit once at latch time turns the signed compare into an
            // unsigned one; it only touches chunk 0 and leaves equality unchanged.
            opA        <= funct3[1] ? dataA : (dataA ^ MSB_MASK);
            opB        <= funct3[1] ? dataB : (dataB ^ MSB_MASK);
            f3Lat      <= funct3;
            chunksLeft <= CW'(N - 1);
            diffSeen   <= 1'b0;
            ltSeen     <= 1'b0;
        end else if (state == BUSY) begin
            opA        <= opA << SHIFT;
            opB        <= opB << SHIFT;
            chunksLeft <= chunksLeft - CW'(1);
            if (!diffSeen && chunkDiff) begin
                diffSeen <= 1'b1;
                ltSeen   <= chunkLt;
            end
            if (exitBusy) begin
                brEq    <= resEq;
                brLt    <= resLt;
                taken   <= resTaken;
                illegal <= resIllegal;
            end
        end
    end

endmodule

// File: tb/tb_branch_cmp_seq.sv
// Bench for branch_cmp_seq: directed cases plus random requests against a behavioural model,
// on a CHUNK=8 and a CHUNK=32 instance.

module tb_branch_cmp_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [2:0]  funct3;
    logic        inValid8, inValid32, outReady8, outReady32;
    logic        inReady8, outValid8, brEq8, brLt8, taken8, illegal8;
    logic        inReady32, outValid32, brEq32, brLt32, taken32, illegal32;
    logic        sel;

    int nTests = 0;
    int nFail  = 0;

`ifdef BRCMP_EARLY_EXIT_EN
    localparam int LAT_BLT = 1;
    localparam int LAT_BGE = 3;
`else
    localparam int LAT_BLT = 4;
    localparam int LAT_BGE = 4;
`endif

    branch_cmp_seq #(.XLEN(32), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(inValid8), .in_ready(inReady8),
        .dataA(dataA), .dataB(dataB), .funct3(funct3),
        .out_valid(outValid8), .out_ready(outReady8),
        .brEq(brEq8), .brLt(brLt8), .taken(taken8), .illegal(illegal8)
    );

    branch_cmp_seq #(.XLEN(32), .CHUNK(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(inValid32), .in_ready(inReady32),
        .dataA(dataA), .dataB(dataB), .funct3(funct3),
        .out_valid(outValid32), .out_ready(outReady32),
        .brEq(brEq32), .brLt(brLt32), .taken(taken32), .illegal(illegal32)
    );

    wire selInReady  = sel ? inReady32  : inReady8;
    wire selOutValid = sel ? outValid32 : outValid8;
    wire selBrEq     = sel ? brEq32     : brEq8;
    wire selBrLt     = sel ? brLt32     : brLt8;
    wire selTaken    = sel ? taken32    : taken8;
    wire selIllegal  = sel ? illegal32  : illegal8;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: whole-word arithmetic compare; latency from the first differing chunk.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                         input int chunk, output logic eq, output logic lt, output logic tk,
                         output logic ill, output int k);
        int n;
        logic [31:0] cm;
        eq  = (a == b);
        lt  = f[1] ? (a < b) : ($signed(a) < $signed(b));
        ill = 1'b0;
        tk  = 1'b0;
        case (f)
            3'd0:       tk = eq;
            3'd1:       tk = !eq;
            3'd4, 3'd6: tk = lt;
            3'd5, 3'd7: tk = !lt;
            default:    ill = 1'b1;
        endcase
        n  = 32 / chunk;
        k  = n;
        cm = (chunk == 32) ? 32'hFFFF_FFFF : ((32'h1 << chunk) - 32'h1);
`ifdef BRCMP_EARLY_EXIT_EN
        for (int i = 0; i < n; i++) begin
            if (((a >> (32 - chunk * (i + 1))) & cm) != ((b >> (32 - chunk * (i + 1))) & cm)) begin
                k = i + 1;
                break;
            end
        end
`endif
    endtask

    task automatic runOp(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, input int hold, input logic eEq, input logic eLt,
                         input logic eTk, input logic eIll, input int eK);
        int cyc;
        sel    = s;
        dataA  = a;
        dataB  = b;
        funct3 = f;
        if (s) inValid32 = 1'b1; else inValid8 = 1'b1;
        #1;
        checkEq("inReadyIdle", {31'd0, selInReady}, 32'd1);
        @(posedge clk); #1;
        inValid8  = 1'b0;
        inValid32 = 1'b0;
        // Scramble the inputs; the latched operands must not notice.
        dataA  = $urandom;
        dataB  = $urandom;
        funct3 = 3'($urandom_range(0, 7));
        cyc = 0;
        while (!selOutValid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkEq("latency", cyc, eK);
        for (int h = 0; h <= hold; h++) begin
            checkEq("outValid", {31'd0, selOutValid}, 32'd1);
            checkEq("inReadyDone", {31'd0, selInReady}, 32'd0);
            checkEq("brEq", {31'd0, selBrEq}, {31'd0, eEq});
            checkEq("brLt", {31'd0, selBrLt}, {31'd0, eLt});
            checkEq("taken", {31'd0, selTaken}, {31'd0, eTk});
            checkEq("illegal", {31'd0, selIllegal}, {31'd0, eIll});
            if (h < hold) begin
                @(posedge clk); #1;
            end
        end
        if (s) outReady32 = 1'b1; else outReady8 = 1'b1;
        @(posedge clk); #1;
        outReady8  = 1'b0;
        outReady32 = 1'b0;
        checkEq("validDrop", {31'd0, selOutValid}, 32'd0);
        checkEq("inReadyBack", {31'd0, selInReady}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        eEq, eLt, eTk, eIll;
        logic        s;
        logic [31:0] a, b;
        logic [2:0]  f;
        int          k, mode;

        rst = 1'b1;
        sel = 1'b0;
        inValid8 = 1'b0; inValid32 = 1'b0; outReady8 = 1'b0; outReady32 = 1'b0;
        dataA = '0; dataB = '0; funct3 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkEq("rstOutValid", {31'd0, outValid8}, 32'd0);
        checkEq("rstInReady", {31'd0, inReady8}, 32'd1);
        checkEq("rstOuts", {28'd0, brEq8, brLt8, taken8, illegal8}, 32'd0);
        checkEq("rstInReady32", {31'd0, inReady32}, 32'd1);

        runOp(1'b0, 32'h1234_5678, 32'h1234_5678, 3'b000, 0, 1'b1, 1'b0, 1'b1, 1'b0, 4);

        // Reset for two cycles in the middle of BUSY (equal operands keep it busy in both builds).
        sel = 1'b0;
        dataA = 32'hCAFE_F00D; dataB = 32'hCAFE_F00D; funct3 = 3'b000;
        inValid8 = 1'b1;
        @(posedge clk); #1;
        inValid8 = 1'b0;
        @(posedge clk); #1;
        checkEq("midBusyValid", {31'd0, outValid8}, 32'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkEq("abortOutValid", {31'd0, outValid8}, 32'd0);
        checkEq("abortOuts", {28'd0, brEq8, brLt8, taken8, illegal8}, 32'd0);
        checkEq("abortInReady", {31'd0, inReady8}, 32'd1);
        repeat (6) @(posedge clk);
        #1;
        checkEq("abortNoResult", {31'd0, outValid8}, 32'd0);

        runOp(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 0, 1'b0, 1'b1, 1'b1, 1'b0, LAT_BLT);
        runOp(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 0, 1'b0, 1'b0, 1'b0, 1'b0, LAT_BLT);
        runOp(1'b0, 32'h0000_0100, 32'h0000_00FF, 3'b101, 5, 1'b0, 1'b0, 1'b1, 1'b0, LAT_BGE);
        runOp(1'b0, 32'h0000_0003, 32'h0000_0003, 3'b011, 0, 1'b1, 1'b0, 1'b0, 1'b1, 4);
        runOp(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1);

        for (int i = 0; i < 200; i++) begin
            s    = ($urandom_range(0, 3) == 0);
            mode = $urandom_range(0, 3);
            a    = $urandom;
            case (mode)
                0:       b = $urandom;
                1:       b = a;
                2:       b = a ^ (32'($urandom_range(1, 255)) << (8 * $urandom_range(0, 3)));
                default: b = a ^ 32'h8000_0000;
            endcase
            f = 3'($urandom_range(0, 7));
            model(a, b, f, s ? 32 : 8, eEq, eLt, eTk, eIll, k);
            runOp(s, a, b, f, $urandom_range(0, 3), eEq, eLt, eTk, eIll, k);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
